// File: rtl/interval_timer_pkg.sv
// Shared constants for the interval timer: register map, MODE codes and FSM state encoding.
package interval_timer_pkg;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef logic [1:0] tmr_state_t;

    localparam tmr_state_t S_IDLE = 2'd0;
    localparam tmr_state_t S_LOAD = 2'd1;
    localparam tmr_state_t S_CNT  = 2'd2;
    localparam tmr_state_t S_INT  = 2'd3;

    // Only the exact reload code reloads; the reserved 1x codes fall back to one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Memory-mapped down-counting timer; drives one CP0 hwint bit with a level irq
// that CP0 masks further, so this block only asserts and holds it.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int unsigned     DW        = 32,
    parameter logic [DW-1:0]   CTRL_MASK = {{(DW-4){1'b0}}, 4'hF}
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [3:0]    addr,
    input  logic          we,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd,
    output logic          irq
);

    localparam logic [DW-1:0] ONE_DW = DW'(1);

    logic [DW-1:0] r_ctrl;
    logic [DW-1:0] r_preset;
    logic [DW-1:0] r_count;
    tmr_state_t    r_state;
    logic          r_irq_flag;

    logic          w_wr_ctrl;
    logic          w_wr_preset;
    logic          w_en;
    logic          w_reload;
    logic          w_expire;
    logic          w_unused_addr;

    assign w_wr_ctrl     = we && (addr[3:2] == TMR_CTRL);
    assign w_wr_preset   = we && (addr[3:2] == TMR_PRESET);
    assign w_en          = r_ctrl[0];
    assign w_reload      = is_reload(r_ctrl[2:1]);
    assign w_expire      = (r_state == S_CNT) && w_en && (r_count <= ONE_DW);
    assign w_unused_addr = ^addr[1:0];

    assign irq = r_irq_flag & r_ctrl[3];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_irq_flag <= 1'b0;
        end else begin
            // A bus write to CTRL overrides the one-shot self-disable in INT.
            if (w_wr_ctrl)
                r_ctrl <= wd & CTRL_MASK;
            else if ((r_state == S_INT) && w_en && !w_reload)
                r_ctrl[0] <= 1'b0;

            if (w_wr_preset)
                r_preset <= wd;

            // Setting the flag outranks every clear so no expiry is ever lost.
            if (w_expire)
                r_irq_flag <= 1'b1;
            else if (w_wr_ctrl || w_wr_preset || ((r_state == S_INT) && w_reload))
                r_irq_flag <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_en)
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    if (!w_en) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_preset;
                        r_state <= S_CNT;
                    end
                end
                S_CNT: begin
                    if (!w_en) begin
                        r_state <= S_IDLE;
                    end else if (r_count > ONE_DW) begin
                        r_count <= r_count - ONE_DW;
                    end else begin
                        r_count <= '0;
                        r_state <= S_INT;
                    end
                end
                S_INT: begin
                    if (w_reload && w_en)
                        r_state <= S_LOAD;
                    else
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (addr[3:2])
            TMR_CTRL:   rd = r_ctrl;
            TMR_PRESET: rd = r_preset;
            TMR_COUNT:  rd = r_count;
            default:    rd = '0;
        endcase
    end

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: cycle-by-cycle comparison against a period/age
// model of the timer, plus hand-computed literal checks at key cycles.
module tb_interval_timer;

    logic        clk;
    logic        clr;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int tests    = 0;
    int failures = 0;

    interval_timer #(.DW(32), .CTRL_MASK(32'h0000_000F)) dut (
        .clk  (clk),
        .clr  (clr),
        .addr (addr),
        .we   (we),
        .wd   (wd),
        .rd   (rd),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: m_age is -1 when stopped, 0 on the reload cycle, 1..len while counting
    // (COUNT = N - (age-1)), len+1 on the interrupt cycle.
    logic [31:0] m_ctrl, m_preset, m_count, m_n;
    longint      m_len;
    longint      m_age;
    bit          m_flag;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        bit wc, wp, en, rl, set_f, clr_f;
        if (clr) begin
            m_ctrl = 0; m_preset = 0; m_count = 0; m_n = 0;
            m_len = 1; m_age = -1; m_flag = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            wc    = we && (addr[3:2] == 2'd0);
            wp    = we && (addr[3:2] == 2'd1);
            en    = m_ctrl[0];
            rl    = (m_ctrl[2:1] == 2'b01);
            set_f = 1'b0;
            clr_f = wc || wp;
            if (m_age < 0) begin
                if (en) m_age = 0;
            end else if (!en) begin
                if (m_age > m_len && rl) clr_f = 1'b1;
                m_age = -1;
            end else if (m_age == 0) begin
                m_n     = m_preset;
                m_len   = (m_preset == 0) ? 1 : longint'(m_preset);
                m_count = m_preset;
                m_age   = 1;
            end else if (m_age < m_len) begin
                m_count = m_n - 32'(m_age);
                m_age   = m_age + 1;
            end else if (m_age == m_len) begin
                m_count = 0;
                set_f   = 1'b1;
                m_age   = m_age + 1;
            end else if (rl) begin
                m_age = 0;
                clr_f = 1'b1;
            end else begin
                m_age     = -1;
                m_ctrl[0] = 1'b0;
            end
            if (set_f)      m_flag = 1'b1;
            else if (clr_f) m_flag = 1'b0;
            if (wc) m_ctrl = wd & 32'h0000_000F;
            if (wp) m_preset = wd;
        end
    end

    function automatic logic [31:0] m_rd(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return m_ctrl;
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            tests++;
            if (rd !== m_rd(addr)) begin
                failures++;
                $display("FAIL model_rd t=%0t addr=%h got %h expected %h", $time, addr, rd, m_rd(addr));
            end
            tests++;
            if (irq !== (m_flag & m_ctrl[3])) begin
                failures++;
                $display("FAIL model_irq t=%0t got %b expected %b", $time, irq, m_flag & m_ctrl[3]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wd = d;
        @(posedge clk);
        #1;
        we = 1'b0; wd = 32'd0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string nm);
        addr = a;
        #1;
        tests++;
        if (rd !== exp) begin
            failures++;
            $display("FAIL %s: rd=%h expected %h", nm, rd, exp);
        end
    endtask

    task automatic irq_chk(input logic exp, input string nm);
        tests++;
        if (irq !== exp) begin
            failures++;
            $display("FAIL %s: irq=%b expected %b", nm, irq, exp);
        end
    endtask

    initial begin
        clr = 1'b1; we = 1'b0; addr = 4'h0; wd = 32'd0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        rd_chk(4'h0, 32'd0, "reset_ctrl");
        rd_chk(4'h4, 32'd0, "reset_preset");
        rd_chk(4'h8, 32'd0, "reset_count");
        irq_chk(1'b0, "reset_irq");

        // One-shot, PRESET=5
        wr(4'h4, 32'd5);
        wr(4'h0, 32'h9);
        step(2);
        rd_chk(4'h8, 32'd5, "oneshot_count5");
        for (int v = 4; v >= 1; v--) begin
            step(1);
            rd_chk(4'h8, 32'(v), "oneshot_countdown");
            irq_chk(1'b0, "oneshot_no_irq_yet");
        end
        step(1);
        irq_chk(1'b1, "oneshot_irq_t2p5");
        step(1);
        rd_chk(4'h0, 32'h8, "oneshot_en_cleared");
        irq_chk(1'b1, "oneshot_irq_held");
        wr(4'h4, 32'd5);
        irq_chk(1'b0, "oneshot_preset_clears");

        // Auto-reload, PRESET=3: period 5
        do_reset();
        wr(4'h4, 32'd3);
        wr(4'h0, 32'hB);
        step(4);
        irq_chk(1'b0, "reload_pre_first");
        step(1);
        irq_chk(1'b1, "reload_first_pulse");
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                step(1);
                irq_chk(1'b0, "reload_gap");
            end
            step(1);
            irq_chk(1'b1, "reload_pulse");
        end

        // Masked expiry, then unmask by CTRL write (clears the flag)
        do_reset();
        wr(4'h4, 32'd2);
        wr(4'h0, 32'h1);
        step(4);
        irq_chk(1'b0, "mask_irq_low");
        step(1);
        rd_chk(4'h0, 32'h0, "mask_en_cleared");
        wr(4'h0, 32'h9);
        irq_chk(1'b0, "mask_write_clears_flag");
        step(3);
        irq_chk(1'b0, "mask_restart_counting");
        step(1);
        irq_chk(1'b1, "mask_restart_irq");

        // Stop mid-count, then restart reloads PRESET
        do_reset();
        wr(4'h4, 32'd10);
        wr(4'h0, 32'h9);
        step(3);
        rd_chk(4'h8, 32'd9, "stop_count9");
        wr(4'h0, 32'h8);
        rd_chk(4'h8, 32'd8, "stop_count8");
        step(3);
        rd_chk(4'h8, 32'd8, "stop_frozen");
        irq_chk(1'b0, "stop_no_irq");
        wr(4'h0, 32'h9);
        step(2);
        rd_chk(4'h8, 32'd10, "stop_reload10");

        // PRESET=0 behaves as 1; writes to COUNT and 0xC ignored
        do_reset();
        wr(4'h4, 32'd0);
        wr(4'h0, 32'h9);
        step(2);
        irq_chk(1'b0, "zero_t2");
        step(1);
        irq_chk(1'b1, "zero_irq_t3");
        step(1);
        wr(4'h8, 32'h1234);
        rd_chk(4'h8, 32'd0, "count_write_ignored");
        wr(4'hC, 32'hFFFF_FFFF);
        rd_chk(4'hC, 32'd0, "reg_c_reads0");
        rd_chk(4'h0, 32'h8, "reg_c_no_ctrl_change");
        irq_chk(1'b1, "reg_c_no_flag_clear");
        wr(4'h0, 32'hFFFF_FFF8);
        rd_chk(4'h0, 32'h8, "ctrl_mask_upper");

        // Expiry coincides with PRESET write; INT coincides with CTRL write
        do_reset();
        wr(4'h4, 32'd2);
        wr(4'h0, 32'h9);
        step(3);
        wr(4'h4, 32'd3);
        irq_chk(1'b1, "set_beats_clear");
        wr(4'h0, 32'h9);
        rd_chk(4'h0, 32'h9, "bus_wins_en_clear");
        irq_chk(1'b0, "int_write_clears");
        step(2);
        rd_chk(4'h8, 32'd3, "restart_new_preset");

        // clr mid-count at COUNT=7
        do_reset();
        wr(4'h4, 32'd9);
        wr(4'h0, 32'h9);
        step(4);
        rd_chk(4'h8, 32'd7, "pre_clr_count7");
        do_reset();
        rd_chk(4'h0, 32'd0, "clr_ctrl");
        rd_chk(4'h4, 32'd0, "clr_preset");
        rd_chk(4'h8, 32'd0, "clr_count");
        irq_chk(1'b0, "clr_irq");
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
